// File: rtl/kdf_verifier_if.sv
// Initiator/target bus between the password verifier and the spongent KDF core.
// master = verifier (drives operands and reset), slave = KDF core.
interface kdf_verifier_if #(
   parameter int unsigned N           = 128,
   parameter int unsigned SALT_WIDTH  = 64,
   parameter int unsigned COUNT_WIDTH = 32,
   parameter int unsigned PSW_WIDTH   = 32
);
   logic                   kdf_rst;
   logic [SALT_WIDTH-1:0]  kdf_salt;
   logic [COUNT_WIDTH-1:0] kdf_count;
   logic [PSW_WIDTH-1:0]   kdf_password;
   logic                   kdf_end_signal;
   logic [N-1:0]           kdf_key;

   modport master (
      output kdf_rst,
      output kdf_salt,
      output kdf_count,
      output kdf_password,
      input  kdf_end_signal,
      input  kdf_key
   );

   modport slave (
      input  kdf_rst,
      input  kdf_salt,
      input  kdf_count,
      input  kdf_password,
      output kdf_end_signal,
      output kdf_key
   );
endinterface

// File: rtl/kdf_verifier.sv
// Password-check front end for the spongent KDF core: runs the KDF on a candidate,
// compares the derived key with the reference, and enforces a failed-attempt lockout.
module kdf_verifier #(
   parameter int unsigned N              = 128,
   parameter int unsigned SALT_WIDTH     = 64,
   parameter int unsigned COUNT_WIDTH    = 32,
   parameter int unsigned PSW_WIDTH      = 32,
   parameter int unsigned MAX_FAILS      = 3,
   parameter int unsigned LOCKOUT_CYCLES = 1024
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic [PSW_WIDTH-1:0]             candidate_password,
   input  logic [SALT_WIDTH-1:0]            stored_salt,
   input  logic [COUNT_WIDTH-1:0]           stored_count,
   input  logic [N-1:0]                     stored_key,
   output logic                             busy,
   output logic                             done,
   output logic                             match,
   output logic                             error,
   output logic                             locked,
   output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count,
   kdf_verifier_if.master                   kdf
);

   localparam int unsigned FCW = $clog2(MAX_FAILS + 1);
   localparam int unsigned TW  = $clog2(LOCKOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_COMPARE,
      S_DONE,
      S_LOCKED
   } state_t;

   state_t                 state_q, state_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   match_q, match_d;
   logic                   error_q, error_d;
   logic                   locked_q, locked_d;
   logic [FCW-1:0]         fail_count_q, fail_count_d;
   logic [TW-1:0]          timer_q, timer_d;
   logic                   kdf_rst_q, kdf_rst_d;
   logic [SALT_WIDTH-1:0]  salt_q, salt_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic [PSW_WIDTH-1:0]   psw_q, psw_d;
   logic [N-1:0]           skey_q, skey_d;
   logic [N-1:0]           key_q, key_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         match_q      <= 1'b0;
         error_q      <= 1'b0;
         locked_q     <= 1'b0;
         fail_count_q <= '0;
         timer_q      <= '0;
         kdf_rst_q    <= 1'b1;
         salt_q       <= '0;
         count_q      <= '0;
         psw_q        <= '0;
         skey_q       <= '0;
         key_q        <= '0;
      end else begin
         state_q      <= state_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         match_q      <= match_d;
         error_q      <= error_d;
         locked_q     <= locked_d;
         fail_count_q <= fail_count_d;
         timer_q      <= timer_d;
         kdf_rst_q    <= kdf_rst_d;
         salt_q       <= salt_d;
         count_q      <= count_d;
         psw_q        <= psw_d;
         skey_q       <= skey_d;
         key_q        <= key_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      match_d      = match_q;
      error_d      = error_q;
      locked_d     = locked_q;
      fail_count_d = fail_count_q;
      timer_d      = timer_q;
      kdf_rst_d    = kdf_rst_q;
      salt_d       = salt_q;
      count_d      = count_q;
      psw_d        = psw_q;
      skey_d       = skey_q;
      key_d        = key_q;

      case (state_q)
         S_IDLE: begin
            kdf_rst_d = 1'b1;
            if (start) begin
               match_d = 1'b0;
               if (stored_count != '0) begin
                  // Operand registers double as the latch; they reach the core in LOAD.
                  state_d = S_LOAD;
                  busy_d  = 1'b1;
                  error_d = 1'b0;
                  salt_d  = stored_salt;
                  count_d = stored_count;
                  psw_d   = candidate_password;
                  skey_d  = stored_key;
               end else begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  error_d = 1'b1;
               end
            end
         end

         S_LOAD: begin
            kdf_rst_d = 1'b0;
            state_d   = S_RUN;
         end

         S_RUN: begin
            if (kdf.kdf_end_signal) begin
               key_d   = kdf.kdf_key;
               state_d = S_COMPARE;
            end
         end

         S_COMPARE: begin
            // match_q is the registered full-width compare result consumed in DONE.
            match_d   = (key_q == skey_q);
            key_d     = '0;
            psw_d     = '0;
            kdf_rst_d = 1'b1;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            state_d   = S_DONE;
         end

         S_DONE: begin
            kdf_rst_d = 1'b1;
            salt_d    = '0;
            count_d   = '0;
            psw_d     = '0;
            skey_d    = '0;
            state_d   = S_IDLE;
            if (!error_q) begin
               if (match_q) begin
                  fail_count_d = '0;
               end else if (fail_count_q == FCW'(MAX_FAILS - 1)) begin
                  fail_count_d = FCW'(MAX_FAILS);
                  locked_d     = 1'b1;
                  timer_d      = TW'(LOCKOUT_CYCLES);
                  state_d      = S_LOCKED;
               end else begin
                  fail_count_d = fail_count_q + FCW'(1);
               end
            end
         end

         S_LOCKED: begin
            if (timer_q <= TW'(1)) begin
               locked_d     = 1'b0;
               fail_count_d = '0;
               timer_d      = '0;
               state_d      = S_IDLE;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end

         default: begin
            state_d   = S_IDLE;
            kdf_rst_d = 1'b1;
         end
      endcase
   end

   assign busy             = busy_q;
   assign done             = done_q;
   assign match            = match_q;
   assign error            = error_q;
   assign locked           = locked_q;
   assign fail_count       = fail_count_q;
   assign kdf.kdf_rst      = kdf_rst_q;
   assign kdf.kdf_salt     = salt_q;
   assign kdf.kdf_count    = count_q;
   assign kdf.kdf_password = psw_q;

endmodule

// File: tb/tb_kdf_verifier.sv
// Directed bench for kdf_verifier with a behavioural stand-in for the KDF core
// whose completion latency and key are known functions of its operands.
module tb_kdf_verifier;
   localparam int unsigned N     = 128;
   localparam int unsigned SW    = 64;
   localparam int unsigned CW    = 32;
   localparam int unsigned PW    = 32;
   localparam logic [63:0] SALT   = 64'h0123456789ABCDEF;
   localparam logic [31:0] PW_OK  = 32'hDEADBEEF;
   localparam logic [31:0] PW_BAD = 32'hDEADBEEE;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [PW-1:0] cand = '0;
   logic [SW-1:0] salt = '0;
   logic [CW-1:0] count = '0;
   logic [N-1:0]  skey = '0;
   logic          busy, done, match, error, locked;
   logic [1:0]    fail_count;
   logic          glitch = 1'b0;

   int total = 0;
   int bad   = 0;

   kdf_verifier_if #(.N(N), .SALT_WIDTH(SW), .COUNT_WIDTH(CW), .PSW_WIDTH(PW)) kdf_if ();

   kdf_verifier #(
      .N(N), .SALT_WIDTH(SW), .COUNT_WIDTH(CW), .PSW_WIDTH(PW),
      .MAX_FAILS(3), .LOCKOUT_CYCLES(16)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .candidate_password(cand), .stored_salt(salt), .stored_count(count), .stored_key(skey),
      .busy(busy), .done(done), .match(match), .error(error), .locked(locked),
      .fail_count(fail_count), .kdf(kdf_if)
   );

   always #5 clk = ~clk;

   function automatic logic [N-1:0] key_of(input logic [63:0] s, input logic [31:0] c,
                                           input logic [31:0] p);
      logic [31:0] m;
      m = p * 32'h9E3779B1;
      return {s ^ {p, ~p}, c ^ m, m ^ 32'h0F0FF0F0};
   endfunction

   // Core stand-in: end_signal high for two cycles, correct key only on the first.
   int cnt = 0;
   int lat_c;
   logic core_end;
   logic [N-1:0] good_key;
   always @(posedge clk) begin
      if (kdf_if.kdf_rst) cnt <= 0;
      else                cnt <= cnt + 1;
   end
   assign lat_c    = 4 + 3 * int'(kdf_if.kdf_count);
   assign core_end = !kdf_if.kdf_rst && (cnt >= lat_c) && (cnt < lat_c + 2);
   assign good_key = key_of(kdf_if.kdf_salt, kdf_if.kdf_count, kdf_if.kdf_password);
   assign kdf_if.kdf_end_signal = core_end | glitch;
   assign kdf_if.kdf_key = (core_end && cnt == lat_c) ? good_key : ~good_key;

   function automatic int exp_lat(input logic [31:0] c);
      return (c == 0) ? 1 : (4 + 3 * int'(c)) + 4;
   endfunction

   task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Caller is at a negedge; returns at the negedge where done is high.
   task automatic do_req(input logic [31:0] pw, input logic [31:0] c, input logic [N-1:0] k,
                         input bit glitch_load, output int lat);
      start = 1'b1; cand = pw; count = c; salt = SALT; skey = k;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      chk("busy_after_start", busy, (c != 0));
      if (c != 0) begin
         chk("load_kdf_rst", kdf_if.kdf_rst, 1'b1);
         chk("load_password", kdf_if.kdf_password, pw);
         if (glitch_load) glitch = 1'b1;
      end
      while (!done && lat < 300) begin
         @(negedge clk);
         glitch = 1'b0;
         lat++;
         if (lat == 2 && c != 0) chk("run_kdf_rst", kdf_if.kdf_rst, 1'b0);
      end
      glitch = 1'b0;
      if (!done) begin
         total++; bad++;
         $display("FAIL done_timeout: got no done want done within 300 cycles");
      end
      chk("busy_at_done", busy, 1'b0);
      chk("kdf_rst_at_done", kdf_if.kdf_rst, 1'b1);
   endtask

   typedef struct {
      logic [31:0] pw;
      logic [31:0] c;
      logic        exp_match;
      logic        exp_error;
      logic [1:0]  exp_fail;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int lat;
      int n;

      vecs[0] = '{PW_OK,  32'd2, 1'b1, 1'b0, 2'd0};
      vecs[1] = '{PW_BAD, 32'd2, 1'b0, 1'b0, 2'd1};
      vecs[2] = '{PW_OK,  32'd2, 1'b1, 1'b0, 2'd0};
      vecs[3] = '{PW_BAD, 32'd2, 1'b0, 1'b0, 2'd1};
      vecs[4] = '{PW_OK,  32'd0, 1'b0, 1'b1, 2'd1};
      vecs[5] = '{PW_BAD, 32'd3, 1'b0, 1'b0, 2'd2};
      vecs[6] = '{PW_OK,  32'd3, 1'b1, 1'b0, 2'd0};
      vecs[7] = '{PW_OK,  32'd0, 1'b0, 1'b1, 2'd0};

      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_match", match, 1'b0);
      chk("rst_error", error, 1'b0);
      chk("rst_locked", locked, 1'b0);
      chk("rst_fail", fail_count, 2'd0);
      chk("rst_kdf_rst", kdf_if.kdf_rst, 1'b1);
      chk("rst_kdf_salt", kdf_if.kdf_salt, '0);
      chk("rst_kdf_pw", kdf_if.kdf_password, '0);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         do_req(vecs[i].pw, vecs[i].c, key_of(SALT, vecs[i].c, PW_OK), 1'b0, lat);
         chk($sformatf("v%0d_match", i), match, vecs[i].exp_match);
         chk($sformatf("v%0d_error", i), error, vecs[i].exp_error);
         chk($sformatf("v%0d_latency", i), lat, exp_lat(vecs[i].c));
         @(negedge clk);
         chk($sformatf("v%0d_done_pulse", i), done, 1'b0);
         chk($sformatf("v%0d_fail", i), fail_count, vecs[i].exp_fail);
         chk($sformatf("v%0d_match_held", i), match, vecs[i].exp_match);
         chk($sformatf("v%0d_idle_pw", i), kdf_if.kdf_password, '0);
      end

      // start held high: one request per IDLE visit
      start = 1'b1; cand = PW_OK; count = 32'd2; salt = SALT; skey = key_of(SALT, 32'd2, PW_OK);
      n = 0;
      @(negedge clk);
      while (!done && n < 300) begin @(negedge clk); n++; end
      chk("held_match1", match, 1'b1);
      @(negedge clk);
      chk("held_idle_busy", busy, 1'b0);
      @(negedge clk);
      chk("held_reaccept_busy", busy, 1'b1);
      start = 1'b0;
      n = 0;
      while (!done && n < 300) begin @(negedge clk); n++; end
      chk("held_match2", match, 1'b1);
      @(negedge clk);
      chk("held_no_third", busy, 1'b0);
      @(negedge clk);
      chk("held_no_third2", busy, 1'b0);

      // end_signal glitches outside RUN
      glitch = 1'b1;
      repeat (2) @(negedge clk);
      chk("glitch_idle_busy", busy, 1'b0);
      chk("glitch_idle_done", done, 1'b0);
      chk("glitch_idle_kdf_rst", kdf_if.kdf_rst, 1'b1);
      chk("glitch_idle_pw", kdf_if.kdf_password, '0);
      glitch = 1'b0;
      @(negedge clk);
      do_req(PW_OK, 32'd2, key_of(SALT, 32'd2, PW_OK), 1'b1, lat);
      chk("glitch_load_match", match, 1'b1);
      chk("glitch_load_latency", lat, exp_lat(32'd2));
      @(negedge clk);

      // lockout
      for (int i = 0; i < 3; i++) begin
         do_req(PW_BAD, 32'd2, key_of(SALT, 32'd2, PW_OK), 1'b0, lat);
         chk("lock_try_match", match, 1'b0);
         chk("lock_not_yet", locked, 1'b0);
         @(negedge clk);
      end
      chk("lock_locked", locked, 1'b1);
      chk("lock_fail", fail_count, 2'd3);
      n = 0;
      while (locked === 1'b1 && n < 100) begin
         start = (n < 12) && (n % 3 == 0);
         cand = PW_OK;
         @(negedge clk);
         start = 1'b0;
         n++;
         chk("lock_no_busy", busy, 1'b0);
         chk("lock_no_done", done, 1'b0);
      end
      chk("lock_len", n, 16);
      chk("lock_fail_clear", fail_count, 2'd0);
      do_req(PW_OK, 32'd2, key_of(SALT, 32'd2, PW_OK), 1'b0, lat);
      chk("post_lock_match", match, 1'b1);
      @(negedge clk);

      // async reset in the 5th RUN cycle
      do_req(PW_BAD, 32'd2, key_of(SALT, 32'd2, PW_OK), 1'b0, lat);
      @(negedge clk);
      chk("pre_rst_fail", fail_count, 2'd1);
      start = 1'b1; cand = PW_OK; count = 32'd2; salt = SALT; skey = key_of(SALT, 32'd2, PW_OK);
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      chk("midrun_busy", busy, 1'b1);
      chk("midrun_kdf_rst", kdf_if.kdf_rst, 1'b0);
      rst = 1'b0;
      #1;
      chk("abort_kdf_rst", kdf_if.kdf_rst, 1'b1);
      chk("abort_busy", busy, 1'b0);
      chk("abort_fail", fail_count, 2'd0);
      chk("abort_pw", kdf_if.kdf_password, '0);
      chk("abort_salt", kdf_if.kdf_salt, '0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      do_req(PW_OK, 32'd2, key_of(SALT, 32'd2, PW_OK), 1'b0, lat);
      chk("post_rst_match", match, 1'b1);
      chk("post_rst_latency", lat, exp_lat(32'd2));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
